exec_monitor: RTL
=================

Name: exec_monitor

Overview:
Synthesizable execution monitor downstream of the pipelined datapath; consumes its PC, stall, branch and forwarding debug outputs. Provides cycle/event counters, halt detection (PC stable for N cycles) and a timeout, replacing bench-only halt logic so FPGA builds can report program completion. Counters are read through a registered address-mapped port.

Parameters:
HALT_CYCLES, 10, consecutive cycles with unchanged PC that declare halt (>=2)
MAX_CYCLES, 5000, RUN cycle limit before timeout
CNT_W, 32, counter width (<=32, zero-extended on read)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  pulse: clear counters, enter RUN
pc_current  in  32  datapath fetch PC
branch_taken  in  1  datapath branch-taken strobe
stall  in  1  datapath hazard stall
forward_a  in  2  forwarding select A
forward_b  in  2  forwarding select B
rd_addr  in  3  counter select
rd_data  out  32  registered read data
state  out  2  0 IDLE, 1 RUN, 2 HALTED, 3 TIMEOUT
halted  out  1  high in HALTED
timeout  out  1  high in TIMEOUT
halt_pc  out  32  PC captured at halt/timeout
trace_idx  in  3  trace entry select (0 = newest)
trace_data  out  32  registered trace PC

Behaviour:
- Reset (reset==0 at clock edge): state IDLE; all counters, prev_pc, stable, halt_pc, rd_data, trace_data = 0; halted=timeout=0. Reset overrides everything, including mid-RUN.
- IDLE: counters hold. start -> RUN.
- Any state, start==1: next state RUN; cycle, stall, branch, fwd, retired counters = 0; stable=0; prev_pc<=pc_current; halt_pc=0. No event counted in the start cycle.
- RUN, each cycle without start: cycle_cnt+1; stall_cnt+1 if stall; branch_cnt+1 if branch_taken; fwd_cnt+1 if forward_a!=0 or forward_b!=0 (at most 1 per cycle); retired_cnt+1 if !stall and pc_current!=prev_pc. All counters saturate at 2^CNT_W-1.
- Stability: pc_current==prev_pc -> stable+1 (saturating at HALT_CYCLES), else stable=0; prev_pc<=pc_current every RUN cycle.
- RUN->HALTED on the edge where the compare matches and stable==HALT_CYCLES-1 (i.e. the HALT_CYCLES-th consecutive match); halt_pc<=pc_current. That cycle's counts still applied.
- RUN->TIMEOUT on the edge where cycle_cnt becomes MAX_CYCLES; halt_pc<=pc_current. Halt and timeout in same cycle: HALTED wins.
- HALTED/TIMEOUT: all counters, halt_pc frozen; only start leaves (reset aside).
- halted/timeout are decodes of registered state (no extra latency vs state).
- Read port: rd_data registered, 1-cycle latency, updated every cycle. Map: 0 cycle_cnt, 1 stall_cnt, 2 branch_cnt, 3 fwd_cnt, 4 retired_cnt, 5 halt_pc, 6 {28'b0, stable[1:0]?no: 30'b0,state}, 7 32'h0000_0000. Read of a counter updating same edge returns pre-update value.

Optional Feature:
MONITOR_TRACE_EN: defined -> 8-entry circular PC trace; in RUN, on every cycle with pc_current!=prev_pc, pc_current written at write pointer, pointer wraps 7->0; start and reset clear entries and pointer. trace_data registered, 1-cycle latency, returns entry (wptr-1-trace_idx) mod 8; unwritten entries read 0. Frozen in HALTED/TIMEOUT. Undefined -> no storage, trace_data constant 0, trace_idx ignored.

Test Plan:
- Reset then start, PC sequence 0,4,8,C then PC held at 0x10 -> HALTED exactly on 10th matching cycle, halt_pc=0x10, rd_addr 4 reads 5 one cycle later.
- RUN with stall high 3 cycles, branch_taken 2 cycles, forward_a=2 and forward_b=1 same cycle -> stall_cnt=3, branch_cnt=2, fwd_cnt=1.
- MAX_CYCLES=20, PC incrementing by 4 forever -> TIMEOUT when cycle_cnt=20, counters frozen at 20 thereafter, halted=0.
- PC stable 9 cycles, changes, stable 10 more -> no halt at 9; halt after second run of 10; start from HALTED -> counters read 0, state RUN.
- reset low mid-RUN at cycle_cnt=7 -> next cycle state IDLE, all reads 0; PC changes ignored until start.
- MONITOR_TRACE_EN: 10 distinct PCs 0x00..0x24 -> trace_idx 0 reads 0x24, idx 7 reads 0x08 (wrap verified); without macro trace_data=0.

Source files
------------

// File: rtl/exec_monitor.sv
// exec_monitor: cycle/event counters, PC-stable halt detection and RUN timeout with a registered read port.
// Define MONITOR_TRACE_EN to add an 8-entry circular trace of fetched PCs.
module exec_monitor #(
    parameter int HALT_CYCLES = 10,
    parameter int MAX_CYCLES  = 5000,
    parameter int CNT_W       = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] pc_current,
    input  logic        branch_taken,
    input  logic        stall,
    input  logic [1:0]  forward_a,
    input  logic [1:0]  forward_b,
    input  logic [2:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic [1:0]  state,
    output logic        halted,
    output logic        timeout,
    output logic [31:0] halt_pc,
    input  logic [2:0]  trace_idx,
    output logic [31:0] trace_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    localparam int STABLE_W = $clog2(HALT_CYCLES + 1);

    state_t              cur_state;
    logic [CNT_W-1:0]    cycle_cnt;
    logic [CNT_W-1:0]    stall_cnt;
    logic [CNT_W-1:0]    branch_cnt;
    logic [CNT_W-1:0]    fwd_cnt;
    logic [CNT_W-1:0]    retired_cnt;
    logic [STABLE_W-1:0] stable;
    logic [31:0]         prev_pc;

    logic                pc_match;
    logic                halt_hit;
    logic                timeout_hit;
    logic [CNT_W-1:0]    cycle_next;
    logic [31:0]         rd_mux;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    assign pc_match    = (pc_current == prev_pc);
    assign cycle_next  = sat_inc(cycle_cnt, 1'b1);
    assign halt_hit    = pc_match && (stable == STABLE_W'(HALT_CYCLES - 1));
    assign timeout_hit = (32'(cycle_next) == 32'(MAX_CYCLES));

    assign state   = cur_state;
    assign halted  = (cur_state == HALTED);
    assign timeout = (cur_state == TIMEOUT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cur_state   <= IDLE;
            cycle_cnt   <= '0;
            stall_cnt   <= '0;
            branch_cnt  <= '0;
            fwd_cnt     <= '0;
            retired_cnt <= '0;
            stable      <= '0;
            prev_pc     <= '0;
            halt_pc     <= '0;
        end else if (start) begin
            cur_state   <= RUN;
            cycle_cnt   <= '0;
            stall_cnt   <= '0;
            branch_cnt  <= '0;
            fwd_cnt     <= '0;
            retired_cnt <= '0;
            stable      <= '0;
            prev_pc     <= pc_current;
            halt_pc     <= '0;
        end else if (cur_state == RUN) begin
            cycle_cnt   <= cycle_next;
            stall_cnt   <= sat_inc(stall_cnt, stall);
            branch_cnt  <= sat_inc(branch_cnt, branch_taken);
            fwd_cnt     <= sat_inc(fwd_cnt, (forward_a != 2'd0) || (forward_b != 2'd0));
            retired_cnt <= sat_inc(retired_cnt, !stall && !pc_match);
            prev_pc     <= pc_current;
            if (!pc_match)
                stable <= '0;
            else if (stable != STABLE_W'(HALT_CYCLES))
                stable <= stable + STABLE_W'(1);
            // Halt takes priority when both limits are reached on the same edge.
            if (halt_hit) begin
                cur_state <= HALTED;
                halt_pc   <= pc_current;
            end else if (timeout_hit) begin
                cur_state <= TIMEOUT;
                halt_pc   <= pc_current;
            end
        end
    end

    // NOTE: the default assignment first keeps this combinational block from inferring a latch.
    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            3'd0:    rd_mux = 32'(cycle_cnt);
            3'd1:    rd_mux = 32'(stall_cnt);
            3'd2:    rd_mux = 32'(branch_cnt);
            3'd3:    rd_mux = 32'(fwd_cnt);
            3'd4:    rd_mux = 32'(retired_cnt);
            3'd5:    rd_mux = halt_pc;
            3'd6:    rd_mux = {30'b0, cur_state};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset)
            rd_data <= '0;
        else
            rd_data <= rd_mux;
    end

`ifdef MONITOR_TRACE_EN
    logic [31:0] trace_mem [8];
    logic [7:0]  trace_valid;
    logic [2:0]  trace_wptr;
    logic [2:0]  trace_rptr;
    logic        trace_wr;

    assign trace_rptr = trace_wptr - 3'd1 - trace_idx;
    assign trace_wr   = reset && !start && (cur_state == RUN) && !pc_match;

    // NOTE: the trace array has no reset; trace_valid masks unwritten entries so the array can map to RAM.
    always_ff @(posedge clock) begin
        if (trace_wr)
            trace_mem[trace_wptr] <= pc_current;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            trace_valid <= '0;
            trace_wptr  <= '0;
            trace_data  <= '0;
        end else begin
            trace_data <= trace_valid[trace_rptr] ? trace_mem[trace_rptr] : '0;
            if (start) begin
                trace_valid <= '0;
                trace_wptr  <= '0;
            end else if (trace_wr) begin
                trace_valid[trace_wptr] <= 1'b1;
                trace_wptr              <= trace_wptr + 3'd1;
            end
        end
    end
`else
    logic unused_trace_idx;
    assign unused_trace_idx = ^trace_idx;
    assign trace_data       = '0;
`endif

endmodule
